lcd_scan_arbiter: RTL and testbench

Owns the 160-nibble LCD segment RAM of the E0C6S46 SoC: CPU addresses 0xE00–0xE4F (lower) and 0xE80–0xECF (upper). It shares that RAM between the CPU memory bus, which always has priority, and a frame scanout sequencer. On each frame request the sequencer streams all 160 nibbles to the video/LCD renderer over a valid/ready handshake. It sits beside the main RAM decode in the SoC top level; the top level muxes `cpu_read_data` into the CPU read bus when `cpu_hit` is high.

---
 rtl/lcd_scan_arbiter.sv | 113 +++++++++++
 tb/tb_lcd_scan_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scan_arbiter.sv
// LCD segment RAM (two segments of SEG_WORDS nibbles) shared between the CPU bus and a
// frame scanout sequencer. The CPU always wins; the scanner only reads when the bus is idle.
module lcd_scan_arbiter #(
  parameter int SEG_WORDS = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_write_en,
  input  logic [3:0]  cpu_write_data,
  output logic [3:0]  cpu_read_data,
  output logic        cpu_hit,
  input  logic        frame_start,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [3:0]  pix_data,
  output logic [7:0]  pix_index,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_overrun
);

  localparam int         TOTAL      = 2 * SEG_WORDS;
  localparam logic [8:0] SEG_W9     = 9'(SEG_WORDS);
  localparam logic [7:0] SEG_W8     = 8'(SEG_WORDS);
  localparam logic [8:0] UPPER_BASE = 9'h080;
  localparam logic [7:0] LAST_IDX   = 8'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  logic [3:0] mem [TOTAL];
  state_t     state_reg;
  logic [7:0] idx_reg;
  logic [8:0] cpu_off;
  logic       lower_hit;
  logic       upper_hit;
  logic [7:0] cpu_idx;

  // Lower segment sits at page offset 0x00, upper segment at 0x80.
  assign cpu_off   = {1'b0, cpu_addr[7:0]};
  assign lower_hit = (cpu_addr[11:8] == 4'hE) && (cpu_off < SEG_W9);
  assign upper_hit = (cpu_addr[11:8] == 4'hE) && (cpu_off >= UPPER_BASE) &&
                     (cpu_off < UPPER_BASE + SEG_W9);
  assign cpu_hit   = lower_hit || upper_hit;
  assign cpu_idx   = upper_hit ? (cpu_addr[7:0] - 8'h80 + SEG_W8) : cpu_addr[7:0];
  assign pix_index = idx_reg;

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (cpu_hit && cpu_write_en) begin
      mem[cpu_idx] <= cpu_write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_read_data <= 4'h0;
    end else if (cpu_hit && !cpu_write_en) begin
      cpu_read_data <= mem[cpu_idx];
    end else begin
      cpu_read_data <= 4'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 8'd0;
      pix_valid     <= 1'b0;
      pix_data      <= 4'h0;
      pix_last      <= 1'b0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= frame_start && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            idx_reg   <= 8'd0;
            busy      <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          // Any CPU access to the array this cycle owns the port; retry next cycle.
          if (!cpu_hit) begin
            pix_data  <= mem[idx_reg];
            pix_valid <= 1'b1;
            pix_last  <= (idx_reg == LAST_IDX);
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (idx_reg == LAST_IDX) begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_reg + 8'd1;
              state_reg <= FETCH;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scan_arbiter.sv
// Randomised bench for lcd_scan_arbiter: CPU accesses and frame scans are checked
// against a flat nibble-array model indexed by the address map.
module tb_lcd_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic        cpu_write_en = 1'b0;
  logic [3:0]  cpu_write_data = 4'h0;
  logic [3:0]  cpu_read_data;
  logic        cpu_hit;
  logic        frame_start = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [3:0]  pix_data;
  logic [7:0]  pix_index;
  logic        pix_last;
  logic        busy;
  logic        frame_overrun;

  always #5 clk = ~clk;

  lcd_scan_arbiter #(.SEG_WORDS(80)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_write_en(cpu_write_en),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data), .cpu_hit(cpu_hit),
    .frame_start(frame_start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_index(pix_index), .pix_last(pix_last), .busy(busy),
    .frame_overrun(frame_overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int model_mem [160];
  int exp_frame [160];
  int hs_idx [$];
  int hs_data [$];
  bit hs_last [$];

  // Handshake recorder: valid&&ready seen mid-cycle means a transfer on the next edge.
  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      hs_idx.push_back(int'(pix_index));
      hs_data.push_back(int'(pix_data));
      hs_last.push_back(pix_last);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int addr_to_idx(input logic [11:0] a);
    if (a >= 12'hE00 && a < 12'hE50) return int'(a) - 'hE00;
    if (a >= 12'hE80 && a < 12'hED0) return int'(a) - 'hE80 + 80;
    return -1;
  endfunction

  function automatic logic [11:0] idx_to_addr(input int i);
    return (i < 80) ? 12'(32'hE00 + i) : 12'(32'hE80 + i - 80);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
    cpu_addr = a; cpu_write_en = 1'b1; cpu_write_data = d;
    tick();
    if (addr_to_idx(a) >= 0) model_mem[addr_to_idx(a)] = int'(d);
    cpu_addr = 12'h000; cpu_write_en = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 160; i++) cpu_write(idx_to_addr(i), 4'($urandom_range(0, 14)));
  endtask

  task automatic clear_hs();
    hs_idx.delete(); hs_data.delete(); hs_last.delete();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if ({cpu_read_data, pix_valid, pix_data, pix_index, pix_last, busy, frame_overrun} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {cpu_read_data, pix_valid, pix_data, pix_index, pix_last, busy, frame_overrun});
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || cpu_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b hit=%b want 0/0", busy, cpu_hit);
    end
  endtask

  task automatic test_cpu_rw();
    logic [11:0] dir_addr [8];
    logic [11:0] a;
    int exp_d;
    dir_addr = '{12'hE00, 12'hE4F, 12'hE80, 12'hE50, 12'hED0, 12'hE7F, 12'hEFF, 12'hDFF};
    cpu_write(12'hE00, 4'hA);
    cpu_write(12'hE4F, 4'h5);
    cpu_write(12'hE80, 4'h3);
    cpu_write(12'hE50, 4'hC);
    cpu_write(12'hED0, 4'hC);
    for (int k = 0; k < 8 + 80; k++) begin
      a = (k < 8) ? dir_addr[k] : 12'($urandom_range(32'hDF0, 32'hEFF));
      if (k >= 8 && $urandom_range(0, 1) == 1) begin
        cpu_write(a, 4'($urandom_range(0, 15)));
      end else begin
        cpu_addr = a; cpu_write_en = 1'b0;
        #1;
        vectors++;
        if (cpu_hit !== (addr_to_idx(a) >= 0)) begin
          miscompares++;
          $display("FAIL cpu_hit @%h: got %b want %b", a, cpu_hit, addr_to_idx(a) >= 0);
        end
        tick();
        exp_d = (addr_to_idx(a) >= 0) ? model_mem[addr_to_idx(a)] : 0;
        vectors++;
        if (int'(cpu_read_data) !== exp_d) begin
          miscompares++;
          $display("FAIL cpu_read @%h: got %h want %h", a, cpu_read_data, exp_d);
        end
        cpu_addr = 12'h000;
      end
      $display("cpu access %0d addr=%h done", k, a);
    end
    tick();
    vectors++;
    if (cpu_read_data !== 4'h0) begin
      miscompares++;
      $display("FAIL cpu_read_idle: got %h want 0", cpu_read_data);
    end
  endtask

  task automatic test_full_scan();
    int busy_cycles;
    int guard;
    for (int i = 0; i < 160; i++) cpu_write(idx_to_addr(i), 4'(i % 16));
    clear_hs();
    pix_ready = 1'b1;
    start_frame();
    vectors++;
    if (busy !== 1'b1 || pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_entry: got busy=%b valid=%b want 1/0", busy, pix_valid);
    end
    busy_cycles = 1;
    tick();
    if (busy) busy_cycles++;
    vectors++;
    if (pix_valid !== 1'b1 || pix_index !== 8'd0) begin
      miscompares++;
      $display("FAIL first_valid: got valid=%b idx=%0d want 1/0", pix_valid, pix_index);
    end
    guard = 0;
    while (busy && guard < 1000) begin
      tick(); guard++;
      if (busy) busy_cycles++;
    end
    vectors++;
    if (busy_cycles !== 320) begin
      miscompares++;
      $display("FAIL full_busy_cycles: got %0d want 320", busy_cycles);
    end
    vectors++;
    if (hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL full_hs_count: got %0d want 160", hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== i % 16 || hs_last[i] !== (i == 159)) begin
        miscompares++;
        $display("FAIL full_scan[%0d]: got idx=%0d data=%h last=%0b want idx=%0d data=%h last=%0b",
                 i, hs_idx[i], hs_data[i], hs_last[i], i, i % 16, i == 159);
      end
    end
    $display("full scan: %0d handshakes, busy %0d cycles", hs_idx.size(), busy_cycles);
  endtask

  task automatic test_backpressure();
    int guard;
    bit stalled;
    logic [3:0] cap_d;
    load_random();
    exp_frame = model_mem;
    clear_hs();
    pix_ready = 1'b1;
    start_frame();
    stalled = 1'b0; guard = 0;
    while (busy && guard < 3000) begin
      if (pix_valid && pix_index == 8'd5 && !stalled) begin
        cap_d = pix_data; stalled = 1'b1; pix_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick(); guard++;
          vectors++;
          if (pix_valid !== 1'b1 || pix_index !== 8'd5 || pix_data !== cap_d) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%b idx=%0d data=%h want 1/5/%h", k, pix_valid, pix_index, pix_data, cap_d);
          end
        end
        pix_ready = 1'b1;
      end else begin
        pix_ready = ($urandom_range(0, 3) != 0);
      end
      tick(); guard++;
    end
    pix_ready = 1'b1;
    vectors++;
    if (guard >= 3000 || !stalled || hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL bp_frame: got guard=%0d stalled=%0b hs=%0d want <3000/1/160", guard, stalled, hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== exp_frame[i]) begin
        miscompares++;
        $display("FAIL bp_scan[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, hs_idx[i], hs_data[i], i, exp_frame[i]);
      end
    end
    $display("backpressure scan: %0d handshakes", hs_idx.size());
  endtask

  task automatic test_contention();
    int busy_cycles, guard, stall_left, fetch3_at, valid3_at, wr_idx;
    bit stall_started, did_read;
    logic [3:0] wr_d;
    load_random();
    exp_frame = model_mem;
    exp_frame[96] = 15;
    clear_hs();
    pix_ready = 1'b1;
    start_frame();
    busy_cycles = 1; guard = 0; stall_left = 0; stall_started = 1'b0;
    fetch3_at = -1; valid3_at = -1;
    while (busy && guard < 2000) begin
      cpu_addr = 12'h000; cpu_write_en = 1'b0; did_read = 1'b0; wr_idx = -1; wr_d = 4'h0;
      if (fetch3_at < 0 && !pix_valid && pix_index == 8'd3) fetch3_at = busy_cycles;
      if (valid3_at < 0 && pix_valid && pix_index == 8'd3) valid3_at = busy_cycles;
      if (!stall_started && !pix_valid && pix_index == 8'd3) begin
        stall_started = 1'b1; stall_left = 4;
      end
      if (stall_left > 0) begin
        cpu_addr = 12'hE10; did_read = 1'b1;
      end else if (pix_valid && pix_index == 8'd10) begin
        cpu_addr = 12'hE90; cpu_write_en = 1'b1; cpu_write_data = 4'hF; wr_idx = 96; wr_d = 4'hF;
      end else if (pix_valid && pix_index == 8'd12) begin
        cpu_addr = 12'hE01; cpu_write_en = 1'b1; cpu_write_data = 4'hF; wr_idx = 1; wr_d = 4'hF;
      end
      tick(); guard++;
      if (busy) busy_cycles++;
      if (wr_idx >= 0) model_mem[wr_idx] = int'(wr_d);
      if (did_read) begin
        stall_left--;
        vectors++;
        if (int'(cpu_read_data) !== model_mem[16]) begin
          miscompares++;
          $display("FAIL stall_read: got %h want %h", cpu_read_data, model_mem[16]);
        end
      end
    end
    cpu_addr = 12'h000; cpu_write_en = 1'b0;
    vectors++;
    if (valid3_at - fetch3_at !== 5 || fetch3_at < 0) begin
      miscompares++;
      $display("FAIL stall_delay: got %0d cycles (fetch at %0d) want 5", valid3_at - fetch3_at, fetch3_at);
    end
    vectors++;
    if (busy_cycles !== 324) begin
      miscompares++;
      $display("FAIL stall_busy_cycles: got %0d want 324", busy_cycles);
    end
    vectors++;
    if (hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL coh_hs_count: got %0d want 160", hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== exp_frame[i]) begin
        miscompares++;
        $display("FAIL coh_frame1[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, hs_idx[i], hs_data[i], i, exp_frame[i]);
      end
    end
    $display("contention frame: %0d handshakes, busy %0d cycles", hs_idx.size(), busy_cycles);
    // Next frame must pick up the late write to index 1.
    clear_hs();
    start_frame();
    guard = 0;
    while (busy && guard < 1000) begin
      tick(); guard++;
    end
    vectors++;
    if (hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL coh_frame2_count: got %0d want 160", hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== model_mem[i]) begin
        miscompares++;
        $display("FAIL coh_frame2[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, hs_idx[i], hs_data[i], i, model_mem[i]);
      end
    end
    $display("coherency next frame: %0d handshakes", hs_idx.size());
  endtask

  task automatic test_overrun_reset();
    int busy_cycles, guard, overruns;
    bit fired, expect_ovr;
    clear_hs();
    pix_ready = 1'b1;
    start_frame();
    busy_cycles = 1; guard = 0; overruns = 0; fired = 1'b0;
    if (frame_overrun) overruns++;
    while (busy && guard < 1000) begin
      expect_ovr = 1'b0;
      if ((pix_valid && pix_index == 8'd40 && !fired) || (pix_valid && pix_last)) begin
        frame_start = 1'b1; expect_ovr = 1'b1;
        if (pix_index == 8'd40) fired = 1'b1;
      end
      tick(); guard++;
      frame_start = 1'b0;
      if (busy) busy_cycles++;
      if (frame_overrun) overruns++;
      if (expect_ovr) begin
        vectors++;
        if (frame_overrun !== 1'b1) begin
          miscompares++;
          $display("FAIL overrun_pulse: got %b want 1 (idx %0d)", frame_overrun, pix_index);
        end
      end
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || frame_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_not_queued: got busy=%b ovr=%b want 0/0", busy, frame_overrun);
    end
    vectors++;
    if (overruns !== 2 || busy_cycles !== 320 || hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL overrun_frame: got overruns=%0d busy=%0d hs=%0d want 2/320/160", overruns, busy_cycles, hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== model_mem[i]) begin
        miscompares++;
        $display("FAIL overrun_scan[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, hs_idx[i], hs_data[i], i, model_mem[i]);
      end
    end
    $display("overrun frame: %0d overrun pulses", overruns);
    // Asynchronous reset mid-scan.
    start_frame();
    guard = 0;
    while (!(pix_valid && pix_index == 8'd70) && guard < 1000) begin
      tick(); guard++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (guard >= 1000 || {cpu_read_data, pix_valid, pix_data, pix_index, pix_last, busy, frame_overrun} !== 20'h0) begin
      miscompares++;
      $display("FAIL async_reset: got guard=%0d outs=%h want 0", guard, {cpu_read_data, pix_valid, pix_data, pix_index, pix_last, busy, frame_overrun});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_hs();
    start_frame();
    guard = 0;
    while (busy && guard < 1000) begin
      tick(); guard++;
    end
    vectors++;
    if (hs_idx.size() !== 160) begin
      miscompares++;
      $display("FAIL post_reset_count: got %0d want 160", hs_idx.size());
    end
    for (int i = 0; i < hs_idx.size() && i < 160; i++) begin
      vectors++;
      if (hs_idx[i] !== i || hs_data[i] !== model_mem[i]) begin
        miscompares++;
        $display("FAIL post_reset_scan[%0d]: got idx=%0d data=%h want idx=%0d data=%h", i, hs_idx[i], hs_data[i], i, model_mem[i]);
      end
    end
    $display("post-reset frame: %0d handshakes", hs_idx.size());
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_full_scan();
    test_backpressure();
    test_contention();
    test_overrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
